// File: rtl/light_conflict_monitor.sv
// Traffic-light conflict monitor: checks a registered four-way lamp sample
// against the legal N-S-E-W rotation and latches the first fault seen.
module light_conflict_monitor #(
  parameter int GREEN_MIN  = 8,
  parameter int YELLOW_LEN = 4,
  parameter int ALLRED_MAX = 2,
  parameter int DWELL_MAX  = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] north,
  input  logic [2:0] south,
  input  logic [2:0] east,
  input  logic [2:0] west,
  input  logic       clr_fault,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [1:0] active_dir,
  output logic [1:0] phase,
  output logic [7:0] cycle_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GREEN,
    S_YELLOW,
    S_ALLRED,
    S_FAULT
  } state_t;

  localparam logic [2:0] L_GRN = 3'b001;
  localparam logic [2:0] L_YEL = 3'b010;
  localparam logic [2:0] L_RED = 3'b100;

  state_t          state_q, state_d;
  logic [3:0][2:0] lamp_q;
  logic [7:0]      dwell_q, dwell_d;
  logic [7:0]      cyc_q, cyc_d;
  logic [1:0]      dir_q, dir_d;
  logic [2:0]      code_q, code_d;
  logic            any_q, any_d;

  logic [3:0] bad, grn, yel, lit;
  logic [1:0] sel;
  logic       multi, g, y;
  logic [1:0] exp_dir;
  logic [7:0] dwell_inc;
  logic [2:0] fc;
  logic       enter_g;

  always_comb begin
    bad = '0;
    grn = '0;
    yel = '0;
    lit = '0;
    sel = '0;
    for (int i = 0; i < 4; i++) begin
      grn[i] = lamp_q[i] == L_GRN;
      yel[i] = lamp_q[i] == L_YEL;
      lit[i] = lamp_q[i] != L_RED;
      bad[i] = !(grn[i] || yel[i] || !lit[i]);
      if (lit[i]) sel = 2'(i);
    end
    multi     = (lit & (lit - 4'd1)) != 4'd0;
    g         = |grn;
    y         = |yel;
    exp_dir   = dir_q + 2'd1;
    dwell_inc = (dwell_q == 8'hFF) ? 8'hFF : dwell_q + 8'd1;
  end

  // sel is only meaningful once bad/multi are ruled out; those win below
  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    dir_d   = dir_q;
    cyc_d   = cyc_q;
    code_d  = code_q;
    any_d   = any_q;
    fc      = 3'd0;
    enter_g = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (g) begin
          if (any_q || sel == 2'd0) enter_g = 1'b1;
          else fc = 3'd3;
        end else if (y) begin
          fc = 3'd4;
        end
      end
      S_GREEN: begin
        if (g && sel == dir_q) begin
          if (dwell_q >= 8'(DWELL_MAX)) fc = 3'd7;
          else dwell_d = dwell_inc;
        end else if (g) begin
          fc = (sel == exp_dir) ? 3'd4 : 3'd3;
        end else if (y && sel == dir_q) begin
          if (dwell_q < 8'(GREEN_MIN)) begin
            fc = 3'd5;
          end else begin
            state_d = S_YELLOW;
            dwell_d = 8'd1;
          end
        end else begin
          fc = 3'd4;
        end
      end
      S_YELLOW: begin
        if (y && sel == dir_q) begin
          if (dwell_q >= 8'(DWELL_MAX)) fc = 3'd7;
          else dwell_d = dwell_inc;
        end else if (y) begin
          fc = 3'd4;
        end else if (g && sel != exp_dir) begin
          fc = 3'd3;
        end else if (dwell_q != 8'(YELLOW_LEN)) begin
          fc = 3'd6;
        end else if (g) begin
          enter_g = 1'b1;
        end else begin
          state_d = S_ALLRED;
          dwell_d = 8'd1;
        end
      end
      S_ALLRED: begin
        if (g) begin
          if (sel != exp_dir) fc = 3'd3;
          else enter_g = 1'b1;
        end else if (y) begin
          fc = 3'd4;
        end else if (dwell_q >= 8'(ALLRED_MAX)) begin
          fc = 3'd7;
        end else begin
          dwell_d = dwell_inc;
        end
      end
      S_FAULT: begin
        if (clr_fault) begin
          state_d = S_IDLE;
          code_d  = 3'd0;
          dwell_d = 8'd0;
          any_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_q != S_FAULT) begin
      if (|bad) fc = 3'd1;
      else if (multi) fc = 3'd2;
    end
    if (fc != 3'd0) begin
      state_d = S_FAULT;
      code_d  = fc;
      dwell_d = dwell_q;
    end else if (enter_g) begin
      state_d = S_GREEN;
      dir_d   = sel;
      dwell_d = 8'd1;
      any_d   = 1'b0;
      if (sel == 2'd0 && (state_q == S_YELLOW || state_q == S_ALLRED))
        cyc_d = cyc_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      lamp_q  <= {4{L_RED}};
      dwell_q <= 8'd0;
      cyc_q   <= 8'd0;
      dir_q   <= 2'd0;
      code_q  <= 3'd0;
      any_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lamp_q  <= {west, east, south, north};
      dwell_q <= dwell_d;
      cyc_q   <= cyc_d;
      dir_q   <= dir_d;
      code_q  <= code_d;
      any_q   <= any_d;
    end
  end

  always_comb begin
    phase = 2'd0;
    unique case (state_q)
      S_GREEN:  phase = 2'd1;
      S_YELLOW: phase = 2'd2;
      S_FAULT:  phase = 2'd3;
      default:  phase = 2'd0;
    endcase
  end

  assign fault      = state_q == S_FAULT;
  assign fault_code = code_q;
  assign active_dir = dir_q;
  assign cycle_cnt  = cyc_q;

endmodule

// File: tb/tb_light_conflict_monitor.sv
// Bench for light_conflict_monitor: directed scenarios plus a randomized
// rotation run checked against a rule-based reference model.
module tb_light_conflict_monitor;

  localparam int GREEN_MIN  = 8;
  localparam int YELLOW_LEN = 4;
  localparam int ALLRED_MAX = 2;
  localparam int DWELL_MAX  = 64;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] Y = 3'b010;

  localparam int ST_I = 0;
  localparam int ST_G = 1;
  localparam int ST_Y = 2;
  localparam int ST_A = 3;
  localparam int ST_F = 4;

  typedef struct packed {
    logic [11:0] l;
    logic        c;
    logic        r;
  } stim_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr_fault = 1'b0;
  logic [2:0] north = R, south = R, east = R, west = R;
  logic       fault;
  logic [2:0] fault_code;
  logic [1:0] active_dir, phase;
  logic [7:0] cycle_cnt;

  int tests = 0;
  int fails = 0;

  int         m_st = ST_I, m_dir = 0, m_dwell = 0, m_code = 0, m_cyc = 0;
  bit         m_any = 1'b0;
  logic [2:0] m_smp [4] = '{R, R, R, R};

  light_conflict_monitor #(
    .GREEN_MIN (GREEN_MIN),
    .YELLOW_LEN(YELLOW_LEN),
    .ALLRED_MAX(ALLRED_MAX),
    .DWELL_MAX (DWELL_MAX)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .north     (north),
    .south     (south),
    .east      (east),
    .west      (west),
    .clr_fault (clr_fault),
    .fault     (fault),
    .fault_code(fault_code),
    .active_dir(active_dir),
    .phase     (phase),
    .cycle_cnt (cycle_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference: collect every rule broken by the sample, report the lowest.
  task automatic model_step();
    int ng, ny, nbad, d, ex;
    bit [7:1] v;
    bit og, oy, ar;
    if (rst) begin
      m_st = ST_I; m_dir = 0; m_dwell = 0; m_code = 0; m_cyc = 0; m_any = 0;
    end else if (m_st == ST_F) begin
      if (clr_fault) begin
        m_st = ST_I; m_code = 0; m_dwell = 0; m_any = 1;
      end
    end else begin
      ng = 0; ny = 0; nbad = 0; d = 0;
      for (int i = 0; i < 4; i++) begin
        if (m_smp[i] == G) begin ng++; d = i; end
        else if (m_smp[i] == Y) begin ny++; d = i; end
        else if (m_smp[i] != R) nbad++;
      end
      og = ng == 1 && ny == 0;
      oy = ny == 1 && ng == 0;
      ar = ng == 0 && ny == 0;
      ex = (m_dir + 1) % 4;
      v = '0;
      v[1] = nbad > 0;
      v[2] = ng + ny > 1;
      if (og) begin
        if (m_st == ST_I) v[3] = !(m_any || d == 0);
        else if (m_st == ST_G) begin
          v[3] = d != m_dir && d != ex;
          v[4] = d == ex;
        end else v[3] = d != ex;
      end
      if (oy) v[4] = !((m_st == ST_G || m_st == ST_Y) && d == m_dir);
      if (ar && m_st == ST_G) v[4] = 1;
      v[5] = m_st == ST_G && oy && d == m_dir && m_dwell < GREEN_MIN;
      v[6] = m_st == ST_Y && (og || ar) && m_dwell != YELLOW_LEN;
      v[7] = (((m_st == ST_G && og) || (m_st == ST_Y && oy)) && d == m_dir
              && m_dwell + 1 > DWELL_MAX)
          || (m_st == ST_A && ar && m_dwell + 1 > ALLRED_MAX);
      if (v != 0) begin
        for (int k = 7; k >= 1; k--) if (v[k]) m_code = k;
        m_st = ST_F;
      end else if (og && m_st != ST_G) begin
        if (d == 0 && (m_st == ST_Y || m_st == ST_A)) m_cyc = (m_cyc + 1) % 256;
        m_st = ST_G; m_dir = d; m_dwell = 1; m_any = 0;
      end else if (oy && m_st == ST_G) begin
        m_st = ST_Y; m_dwell = 1;
      end else if (og || oy || m_st == ST_A) begin
        m_dwell = (m_dwell < 255) ? m_dwell + 1 : 255;
      end else if (m_st == ST_Y) begin
        m_st = ST_A; m_dwell = 1;
      end
    end
    if (rst) m_smp = '{R, R, R, R};
    else m_smp = '{north, south, east, west};
  endtask

  function automatic logic [11:0] lamps(input int d, input logic [2:0] c);
    logic [11:0] v;
    v = {R, R, R, R};
    if (d >= 0) v[d*3 +: 3] = c;
    return v;
  endfunction

  task automatic drive(input logic [11:0] l, input logic c, input logic r);
    @(negedge clk);
    {west, east, south, north} = l;
    clr_fault = c;
    rst = r;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic hold(input int d, input logic [2:0] c, input int n);
    for (int i = 0; i < n; i++) drive(lamps(d, c), 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    drive(lamps(-1, R), 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    drive({R, R, R, 3'b111}, 1'b1, 1'b1);
    drive(lamps(1, G), 1'b0, 1'b1);
    tests++;
    if ({fault, fault_code, active_dir, phase, cycle_cnt} !== 16'h0) begin
      fails++;
      $display("FAIL reset: f=%b code=%b dir=%0d ph=%0d cyc=%0d, required all 0",
               fault, fault_code, active_dir, phase, cycle_cnt);
    end
    hold(-1, R, 3);
    tests++;
    if (phase !== 2'd0 || fault !== 1'b0) begin
      fails++;
      $display("FAIL idle_hold: ph=%0d f=%b, required 0/0", phase, fault);
    end
  endtask

  task automatic test_rotation();
    do_reset();
    for (int d = 0; d < 4; d++) begin
      hold(d, G, GREEN_MIN);
      hold(d, Y, YELLOW_LEN);
      tests++;
      if (fault !== 1'b0 || phase !== 2'd2 || active_dir !== 2'(d)) begin
        fails++;
        $display("FAIL rot_dir%0d: f=%b ph=%0d dir=%0d, required 0/2/%0d",
                 d, fault, phase, active_dir, d);
      end
    end
    tests++;
    if (cycle_cnt !== 8'd0) begin
      fails++;
      $display("FAIL rot_cnt0: cyc=%0d, required 0", cycle_cnt);
    end
    hold(0, G, 2);
    tests++;
    if (cycle_cnt !== 8'd1 || phase !== 2'd1 || active_dir !== 2'd0 || fault !== 1'b0) begin
      fails++;
      $display("FAIL rot_cnt1: cyc=%0d ph=%0d dir=%0d f=%b, required 1/1/0/0",
               cycle_cnt, phase, active_dir, fault);
    end
  endtask

  task automatic test_conflict();
    do_reset();
    drive({R, G, R, G}, 1'b0, 1'b0);
    tests++;
    if (fault !== 1'b0) begin
      fails++;
      $display("FAIL conflict_early: f=%b, required 0 one edge after", fault);
    end
    drive({R, G, R, G}, 1'b0, 1'b0);
    tests++;
    if (fault !== 1'b1 || fault_code !== 3'b010) begin
      fails++;
      $display("FAIL conflict: f=%b code=%b, required 1/010", fault, fault_code);
    end
  endtask

  task automatic test_short_green();
    do_reset();
    hold(0, G, 5);
    hold(0, Y, 2);
    tests++;
    if (fault_code !== 3'b101 || phase !== 2'd3 || active_dir !== 2'd0) begin
      fails++;
      $display("FAIL short_green: code=%b ph=%0d dir=%0d, required 101/3/0",
               fault_code, phase, active_dir);
    end
  endtask

  task automatic test_long_yellow();
    do_reset();
    hold(0, G, GREEN_MIN);
    hold(0, Y, YELLOW_LEN);
    hold(1, G, GREEN_MIN);
    hold(1, Y, 6);
    hold(2, G, 2);
    tests++;
    if (fault_code !== 3'b110 || fault !== 1'b1 || active_dir !== 2'd1) begin
      fails++;
      $display("FAIL long_yellow: code=%b f=%b dir=%0d, required 110/1/1",
               fault_code, fault, active_dir);
    end
  endtask

  task automatic test_bad_code_clear();
    do_reset();
    drive({3'b011, R, R, R}, 1'b0, 1'b0);
    drive({3'b011, R, R, R}, 1'b0, 1'b0);
    tests++;
    if (fault_code !== 3'b001 || fault !== 1'b1) begin
      fails++;
      $display("FAIL bad_code: code=%b f=%b, required 001/1", fault_code, fault);
    end
    drive(lamps(-1, R), 1'b1, 1'b0);
    tests++;
    if (fault !== 1'b0 || fault_code !== 3'b000 || phase !== 2'd0) begin
      fails++;
      $display("FAIL clear: f=%b code=%b ph=%0d, required 0/000/0",
               fault, fault_code, phase);
    end
    hold(-1, R, 1);
    hold(2, G, 2);
    tests++;
    if (phase !== 2'd1 || fault !== 1'b0 || active_dir !== 2'd2) begin
      fails++;
      $display("FAIL any_dir: ph=%0d f=%b dir=%0d, required 1/0/2",
               phase, fault, active_dir);
    end
  endtask

  task automatic test_reset_midphase();
    do_reset();
    for (int d = 0; d < 2; d++) begin
      hold(d, G, GREEN_MIN);
      hold(d, Y, YELLOW_LEN);
    end
    hold(2, G, GREEN_MIN);
    hold(2, Y, 2);
    tests++;
    if (phase !== 2'd2 || active_dir !== 2'd2) begin
      fails++;
      $display("FAIL pre_rst: ph=%0d dir=%0d, required 2/2", phase, active_dir);
    end
    drive(lamps(2, Y), 1'b0, 1'b1);
    tests++;
    if ({fault, fault_code, active_dir, phase, cycle_cnt} !== 16'h0) begin
      fails++;
      $display("FAIL mid_rst: f=%b code=%b dir=%0d ph=%0d cyc=%0d, required all 0",
               fault, fault_code, active_dir, phase, cycle_cnt);
    end
    hold(0, G, GREEN_MIN);
    hold(0, Y, YELLOW_LEN);
    hold(1, G, 2);
    tests++;
    if (fault !== 1'b0 || phase !== 2'd1 || active_dir !== 2'd1) begin
      fails++;
      $display("FAIL post_rst: f=%b ph=%0d dir=%0d, required 0/1/1",
               fault, phase, active_dir);
    end
  endtask

  task automatic test_timeouts();
    do_reset();
    hold(0, G, DWELL_MAX);
    tests++;
    if (fault !== 1'b0) begin
      fails++;
      $display("FAIL dwell_ok: f=%b, required 0", fault);
    end
    hold(0, G, 3);
    tests++;
    if (fault_code !== 3'b111 || fault !== 1'b1) begin
      fails++;
      $display("FAIL dwell_max: code=%b f=%b, required 111/1", fault_code, fault);
    end
    do_reset();
    hold(0, G, GREEN_MIN);
    hold(0, Y, YELLOW_LEN);
    hold(-1, R, ALLRED_MAX + 1);
    tests++;
    if (fault !== 1'b0 || phase !== 2'd0) begin
      fails++;
      $display("FAIL allred_ok: f=%b ph=%0d, required 0/0", fault, phase);
    end
    hold(-1, R, 2);
    tests++;
    if (fault_code !== 3'b111 || active_dir !== 2'd0) begin
      fails++;
      $display("FAIL allred_max: code=%b dir=%0d, required 111/0", fault_code, active_dir);
    end
  endtask

  function automatic stim_t mk(input int d, input logic [2:0] c, input logic cl,
                               input logic r);
    stim_t s;
    s.l = lamps(d, c);
    if ($urandom_range(0, 49) == 0) s.l[$urandom_range(0, 3)*3 +: 3] = 3'($urandom);
    s.c = cl;
    s.r = r;
    return s;
  endfunction

  task automatic test_random();
    stim_t q[$];
    int d, gl, yl, al;
    logic [15:0] e;
    do_reset();
    d = 0;
    for (int r = 0; r < 240; r++) begin
      if ($urandom_range(0, 39) == 0) begin
        q.push_back(mk(-1, R, 1'b0, 1'b1));
        d = 0;
      end
      gl = GREEN_MIN - 1 + $urandom_range(0, 3);
      yl = YELLOW_LEN + (($urandom_range(0, 5) == 0) ? $urandom_range(0, 2) - 1 : 0);
      al = $urandom_range(0, ALLRED_MAX + 1);
      for (int k = 0; k < gl; k++) q.push_back(mk(d, G, 1'b0, 1'b0));
      for (int k = 0; k < yl; k++) q.push_back(mk(d, Y, 1'b0, 1'b0));
      if ($urandom_range(0, 1) == 0) q.push_back(mk(-1, R, 1'b1, 1'b0));
      for (int k = 0; k < al; k++) q.push_back(mk(-1, R, 1'b0, 1'b0));
      d = ($urandom_range(0, 11) == 0) ? $urandom_range(0, 3) : (d + 1) % 4;
    end
    foreach (q[i]) begin
      drive(q[i].l, q[i].c, q[i].r);
      e = {m_st == ST_F, 3'(m_code), 2'(m_dir),
           (m_st == ST_F) ? 2'd3 : (m_st == ST_G) ? 2'd1 : (m_st == ST_Y) ? 2'd2 : 2'd0,
           8'(m_cyc)};
      tests++;
      if ({fault, fault_code, active_dir, phase, cycle_cnt} !== e) begin
        fails++;
        $display("FAIL random[%0d]: f/code/dir/ph/cyc=%b/%b/%0d/%0d/%0d, required %b/%b/%0d/%0d/%0d",
                 i, fault, fault_code, active_dir, phase, cycle_cnt,
                 e[15], e[14:12], e[11:10], e[9:8], e[7:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_conflict();
    test_short_green();
    test_long_yellow();
    test_bad_code_clear();
    test_reset_midphase();
    test_timeouts();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/light_conflict_monitor.md
LIGHT_CONFLICT_MONITOR -- requirements
Module: light_conflict_monitor

Interface
REQ-001 The block SHALL have parameter GREEN_MIN, default 8, meaning minimum legal green dwell in cycles.
REQ-002 The block SHALL have parameter YELLOW_LEN, default 4, meaning exact legal yellow dwell in cycles.
REQ-003 The block SHALL have parameter ALLRED_MAX, default 2, meaning maximum legal all-red samples between yellow and next green.
REQ-004 The block SHALL have parameter DWELL_MAX, default 64, meaning timeout for any single green or yellow phase (all parameters 1..255).
REQ-005 The block SHALL have port clk, input, 1 bit: single clock, all logic on rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have ports north, south, east, west, input, 3 bits each: lamp code, 3'b001 green, 3'b010 yellow, 3'b100 red.
REQ-008 The block SHALL have port clr_fault, input, 1 bit: synchronous fault clear.
REQ-009 The block SHALL have port fault, output, 1 bit: latched fault flag.
REQ-010 The block SHALL have port fault_code, output, 3 bits: first-fault cause.
REQ-011 The block SHALL have port active_dir, output, 2 bits: 0 north, 1 south, 2 east, 3 west.
REQ-012 The block SHALL have port phase, output, 2 bits: 0 idle/all-red, 1 green, 2 yellow, 3 fault.
REQ-013 The block SHALL have port cycle_cnt, output, 8 bits: completed N-S-E-W rotations.

Function
REQ-014 The block SHALL register the four lamp inputs each edge; all checks SHALL use the registered sample, so values present at edge N affect outputs after edge N+1.
REQ-015 The block SHALL implement states IDLE, GREEN, YELLOW, ALLRED, FAULT, with phase = 0,1,2,0,3 respectively.
REQ-016 IDLE: all-red samples are held indefinitely; a single green on the expected direction moves to GREEN with dwell=1; after rst the expected direction is north, after clr_fault any direction.
REQ-017 GREEN -> YELLOW when the active direction shows yellow and the others red; the green dwell at that point SHALL be >= GREEN_MIN, else fault 101.
REQ-018 YELLOW -> GREEN on direction (active_dir+1) mod 4, or YELLOW -> ALLRED on all-red; yellow dwell SHALL equal YELLOW_LEN, else fault 110.
REQ-019 ALLRED -> GREEN on direction (active_dir+1) mod 4; a run of more than ALLRED_MAX all-red samples SHALL raise fault 111.
REQ-020 Dwell counter SHALL count samples in the current phase, reset to 1 on phase entry, and saturate at 255.
REQ-021 GREEN or YELLOW dwell exceeding DWELL_MAX SHALL raise fault 111.
REQ-022 Any lamp code that is not one-hot SHALL raise fault 001.
REQ-023 More than one non-red direction SHALL raise fault 010.
REQ-024 Green on a direction other than the expected one SHALL raise fault 011.
REQ-025 Any illegal transition (green->red, green->green on another direction, yellow->yellow on another direction, red->yellow) SHALL raise fault 100.
REQ-026 On simultaneous faults, priority SHALL be 001 > 010 > 011 > 100 > 101 > 110 > 111; only the first fault is latched.
REQ-027 On a fault the block SHALL enter FAULT, set fault=1, and hold fault_code, active_dir and cycle_cnt until clr_fault or rst.
REQ-028 clr_fault in FAULT SHALL return to IDLE with fault=0 and fault_code=0 on the next edge; clr_fault outside FAULT SHALL be ignored; rst SHALL override clr_fault.
REQ-029 cycle_cnt SHALL increment by 1 on each legal entry into north GREEN from west YELLOW/ALLRED, wrapping 255->0.
REQ-030 active_dir SHALL update on each GREEN entry and be held in YELLOW/ALLRED.

Reset
REQ-031 With rst high at an edge: state=IDLE, expected direction north, fault=0, fault_code=0, active_dir=0, phase=0, cycle_cnt=0, dwell=0, input register=all red.
REQ-032 Reset asserted mid-phase SHALL abandon the phase with no fault generated.

Verification
REQ-033 Legal rotation (8 green, 4 yellow per direction, N-S-E-W): no fault, and cycle_cnt goes 0->1 after the second north green entry.
REQ-034 North green and east green together: fault=1, fault_code=010 two edges after application.
REQ-035 North yellow after 5 green samples: fault_code=101, phase=3, active_dir=0.
REQ-036 South yellow held for 6 cycles then east green: fault_code=110.
REQ-037 west=3'b011 with others red: fault_code=001; clr_fault pulse, then all-red, then any-direction green -> phase=1, fault=0.
REQ-038 rst asserted during east yellow: all outputs at reset values next cycle; a following legal north rotation produces no fault.
